rx_block: RTL
=============

RX_BLOCK -- requirements
Module: rx_block

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving the number of clk_en ticks per bit period; it SHALL be even and at least 4.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 clk_en  input  1  single-cycle oversample tick at OVERSAMPLE times the baud rate.
REQ-005 rx_in  input  1  serial line; idles high; frame is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-006 mdata  output  8  last correctly received byte.
REQ-007 valid  output  1  one-clk pulse when a new byte is on mdata.
REQ-008 frame_err  output  1  one-clk pulse when the stop bit samples low.
REQ-009 busy  output  1  high while any state other than IDLE is active.

Function
REQ-010 The states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; the state, tick counter (ceil(log2(OVERSAMPLE)) bits) and bit counter (3 bits) SHALL advance only on cycles with clk_en high, except where stated otherwise.
REQ-011 In IDLE, a low sample of the line on a clk_en cycle SHALL move to START with the tick counter cleared.
REQ-012 In START, the line SHALL be sampled when the tick counter reaches OVERSAMPLE/2-1: if low, go to DATA with the tick and bit counters cleared; if high (glitch), return to IDLE without asserting any output.
REQ-013 In DATA, the line SHALL be sampled when the tick counter reaches OVERSAMPLE-1, then the tick counter clears and the bit shifts into the shift register MSB-first, so the first received bit ends in bit 0.
REQ-014 After the 8th data sample (bit counter 7), the FSM SHALL go to STOP.
REQ-015 In STOP, the line SHALL be sampled at tick OVERSAMPLE-1: if high, mdata SHALL load the shift register and valid SHALL pulse for exactly one clk on the following cycle; the FSM then returns to IDLE.
REQ-016 If the stop sample is low, frame_err SHALL pulse for one clk, mdata SHALL keep its previous value, valid SHALL stay low, and the FSM SHALL enter WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL return to IDLE on the first clk_en-cycle high sample; a held-low line (break) SHALL never start a new frame.
REQ-018 valid and frame_err SHALL never be high in the same cycle.
REQ-019 mdata SHALL hold its value until the next valid.
REQ-020 A start edge sampled on the clk_en cycle that returns the FSM to IDLE SHALL NOT be detected; detection begins on the next clk_en.
REQ-021 clk_en held low SHALL freeze all state; no output SHALL change.

Reset
REQ-022 While rst_n is low: state=IDLE, all counters=0, shift register=0x00, mdata=0x00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err; after release, reception SHALL restart only on a new falling edge seen in IDLE.

Configuration
REQ-024 With macro RX_SYNC_EN defined, rx_in SHALL pass through a two-flop synchronizer (clocked every clk, reset to 1) before all sampling, adding 2 clk of input latency.
REQ-025 Without RX_SYNC_EN, rx_in SHALL be sampled directly; all other behaviour SHALL be identical.

Verification
REQ-026 Frame 0xA5 at OVERSAMPLE=16 with continuous clk_en every 4 clk -> one valid pulse, mdata=0xA5, frame_err never high.
REQ-027 Back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses, mdata 0x00 then 0xFF.
REQ-028 Line low for 4 ticks then high -> FSM returns to IDLE after the start check; no valid and no frame_err.
REQ-029 Frame 0x3C with stop bit low, line then held low 40 ticks -> one frame_err pulse; mdata unchanged; busy high until the first high sample; no further events.
REQ-030 rst_n pulsed low during data bit 4 of a 0x81 frame, then frame 0x5A sent -> no event for the aborted frame; valid with mdata=0x5A.
REQ-031 Frame 0x96 with clk_en gated off for 50 clk mid-frame -> outputs frozen during the gap; reception completes with mdata=0x96; run with and without RX_SYNC_EN.

Source files
------------

// File: rtl/rx_block.sv
// 8N1 UART receiver oversampling at OVERSAMPLE clk_en ticks per bit; define RX_SYNC_EN for a 2-flop input synchronizer.
// Latency: valid/frame_err one clk after the mid-stop-bit sample (+2 clk with RX_SYNC_EN); no backpressure, clk_en low freezes all state.
module rx_block #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       rx_in,
    output logic [7:0] mdata,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tick, tick_nxt;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shift, shift_nxt;
    logic [7:0]     mdata_nxt;
    logic           valid_nxt, frame_err_nxt;
    logic           rx_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= 2'b11;
        else        sync_ff <= {sync_ff[0], rx_in};
    end

    assign rx_s = sync_ff[1];
`else
    assign rx_s = rx_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            mdata     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick      <= tick_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            mdata     <= mdata_nxt;
            valid     <= valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Pulses are cleared every clk; everything else only moves on clk_en.
    always_comb begin
        state_nxt     = state;
        tick_nxt      = tick;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        mdata_nxt     = mdata;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick == HALF_TICK) begin
                        if (!rx_s) begin
                            state_nxt   = DATA;
                            tick_nxt    = '0;
                            bit_cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                DATA: begin
                    if (tick == FULL_TICK) begin
                        tick_nxt    = '0;
                        shift_nxt   = {rx_s, shift[7:1]};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nxt = STOP;
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                STOP: begin
                    if (tick == FULL_TICK) begin
                        tick_nxt = '0;
                        if (rx_s) begin
                            mdata_nxt = shift;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            frame_err_nxt = 1'b1;
                            state_nxt     = WAIT_HIGH;
                        end
                    end else begin
                        tick_nxt = tick + TW'(1);
                    end
                end
                // A break must see the line high once before a new start can be hunted.
                WAIT_HIGH: begin
                    if (rx_s) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
